// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared constants and encodings for the memory access unit.
//   DATA_W/ADDR_W  - data and address widths of the memory port
//   MEM_DEPTH      - number of valid word addresses (0..MEM_DEPTH-1)
//   MAX_BURST      - longest legal burst load in words
//   op_e           - request opcodes carried on req_op
//   state_e        - access FSM states
package mem_access_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int MEM_DEPTH = 512;
  localparam int MAX_BURST = 8;

  typedef enum logic [1:0] {
    OP_LOAD       = 2'd0,
    OP_STORE      = 2'd1,
    OP_BURST_LOAD = 2'd2,
    OP_RSVD       = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_access_unit_addr_check.sv
// mem_addr_check: combinational effective-address and fault evaluation.
//   op_i      - request opcode
//   base_i    - base register value
//   offset_i  - signed word offset (two's complement, added modulo 2^ADDR_W)
//   req_len_i - requested burst length (burst loads only)
//   ea_o      - effective address base+offset, wrapped to ADDR_W bits
//   len_o     - normalized transfer length (1 for single-word ops)
//   fault_o   - reserved op, illegal length, or any word outside the memory
module mem_addr_check
  import mem_access_pkg::*;
(
  input  logic [1:0]        op_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] offset_i,
  input  logic [3:0]        req_len_i,
  output logic [ADDR_W-1:0] ea_o,
  output logic [3:0]        len_o,
  output logic              fault_o
);

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(MEM_DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_X     = (ADDR_W+1)'(1);

  logic [ADDR_W:0] end_addr;
  logic            len_bad;

  always_comb begin
    ea_o    = base_i + offset_i;
    len_o   = 4'd1;
    len_bad = 1'b0;
    if (op_i == OP_BURST_LOAD) begin
      len_o   = req_len_i;
      len_bad = (req_len_i == 4'd0) || (req_len_i > 4'(MAX_BURST));
    end
    // One extra bit so a burst running past the top of the address space
    // is seen as out of range instead of wrapping back to low addresses.
    end_addr = {1'b0, ea_o} + (ADDR_W+1)'(len_o) - ONE_X;
    fault_o  = (op_i == OP_RSVD) || len_bad ||
               ({1'b0, ea_o} > LAST_ADDR) || (end_addr > LAST_ADDR);
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end in front of the data memory.
//   clk, reset_n           - clock (rising edge), async active-low reset
//   req_*                  - request channel (valid/ready), op/base/offset/len/data
//   resp_*                 - response channel (valid/ready), data/last/error
//   mem_*                  - data memory port; read data is combinational
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; fault check done at accept
// ACCESS| registered memory strobes active for one word; read data captured
// RESP  | response held until resp_ready; burst steps to next word
// FAULT | single error response, memory untouched
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_offset,
  input  logic [3:0]        req_len,
  input  logic [DATA_W-1:0] req_store_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_last,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        rem_q, rem_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;

  logic [ADDR_W-1:0] ea;
  logic [3:0]        len;
  logic              fault;

  mem_addr_check u_addr_check (
    .op_i      (req_op),
    .base_i    (req_base),
    .offset_i  (req_offset),
    .req_len_i (req_len),
    .ea_o      (ea),
    .len_o     (len),
    .fault_o   (fault)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    rdata_d     = rdata_q;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          op_d   = req_op;
          addr_d = ea;
          rem_d  = len;
          if (fault) begin
            state_d = ST_FAULT;
          end else begin
            // Memory strobes are registered, so they are loaded on the way
            // into ACCESS and are live for exactly that one cycle.
            state_d     = ST_ACCESS;
            mem_addr_d  = ea;
            mem_we_d    = (req_op == OP_STORE);
            mem_re_d    = (req_op != OP_STORE);
            mem_wdata_d = (req_op == OP_STORE) ? req_store_data : '0;
          end
        end
      end
      ST_ACCESS: begin
        rdata_d = (op_q == OP_STORE) ? '0 : mem_read_data;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          rem_d = rem_q - 4'd1;
          if (rem_q > 4'd1) begin
            addr_d     = addr_q + ADDR_W'(1);
            mem_addr_d = addr_q + ADDR_W'(1);
            mem_re_d   = 1'b1;
            state_d    = ST_ACCESS;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_FAULT: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered so req_ready stays low while reset is held.
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
    end
  end

  assign req_ready        = ready_q;
  assign resp_valid       = (state_q == ST_RESP) || (state_q == ST_FAULT);
  assign resp_error       = (state_q == ST_FAULT);
  assign resp_last        = (state_q == ST_FAULT) || ((state_q == ST_RESP) && (rem_q == 4'd1));
  assign resp_data        = (state_q == ST_RESP) ? rdata_q : '0;
  assign mem_address      = mem_addr_q;
  assign mem_write_data   = mem_wdata_q;
  assign mem_write_enable = mem_we_q;
  assign mem_read_enable  = mem_re_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized requests against a word-array
// memory, with expected responses computed from the address/length rules.
module tb_mem_access_unit;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_base;
  logic [15:0] req_offset;
  logic [3:0]  req_len;
  logic [15:0] req_store_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        resp_last;
  logic        resp_error;
  logic [15:0] mem_address;
  logic [15:0] mem_write_data;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [15:0] mem_read_data;

  logic [15:0] mem     [0:511];
  logic [15:0] ref_mem [0:511];

  int n_pass;
  int n_total;

  mem_access_unit dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_base         (req_base),
    .req_offset       (req_offset),
    .req_len          (req_len),
    .req_store_data   (req_store_data),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_data        (resp_data),
    .resp_last        (resp_last),
    .resp_error       (resp_error),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_read_data    (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on the rising edge.
  assign mem_read_data = (mem_address < 16'd512) ? mem[mem_address[8:0]] : 16'h0000;
  always @(posedge clk) begin
    if (mem_write_enable && mem_address < 16'd512) mem[mem_address[8:0]] <= mem_write_data;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One response beat: hold it for 'stalls' cycles with resp_ready low, then accept.
  task automatic drain_beat(input logic [15:0] exp_data, input bit exp_last,
                            input bit exp_err, input int stalls);
    for (int s = 0; s <= stalls; s++) begin
      check("resp_valid", resp_valid, 1);
      check("resp_data", resp_data, exp_data);
      check("resp_last", resp_last, exp_last);
      check("resp_error", resp_error, exp_err);
      check("resp_mem_re", mem_read_enable, 0);
      check("resp_mem_we", mem_write_enable, 0);
      resp_ready = (s == stalls);
      @(negedge clk);
    end
    resp_ready = 1'b0;
  endtask

  // Issue one request and follow it through every response beat.
  // stall_sel < 0 picks random stalls; otherwise bit b gives one stall on beat b.
  task automatic send(input logic [1:0] op, input logic [15:0] base, input logic [15:0] off,
                      input logic [3:0] len, input logic [15:0] sdata, input int stall_sel);
    int ea, n, w, stalls;
    bit bad;
    logic [15:0] exp_d;
    ea  = (int'(base) + int'(off)) % 65536;
    n   = (op == 2'd2) ? int'(len) : 1;
    bad = (op == 2'd3) || (op == 2'd2 && (len == 4'd0 || len > 4'd8)) ||
          (ea > 511) || (ea + n - 1 > 511);

    w = 0;
    while (req_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_idle", req_ready, 1);
    req_valid      = 1'b1;
    req_op         = op;
    req_base       = base;
    req_offset     = off;
    req_len        = len;
    req_store_data = sdata;
    resp_ready     = 1'($urandom_range(0, 1));
    @(negedge clk);
    req_valid      = 1'b0;
    req_op         = 2'($urandom);
    req_base       = 16'($urandom);
    resp_ready     = 1'b0;
    check("req_ready_busy", req_ready, 0);

    if (bad) begin
      stalls = (stall_sel < 0) ? $urandom_range(0, 2) : 0;
      drain_beat(16'h0000, 1'b1, 1'b1, stalls);
    end else begin
      for (int b = 0; b < n; b++) begin
        check("acc_addr", mem_address, 32'(ea + b));
        check("acc_re", mem_read_enable, (op != 2'd1));
        check("acc_we", mem_write_enable, (op == 2'd1));
        if (op == 2'd1) check("acc_wdata", mem_write_data, sdata);
        resp_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        resp_ready = 1'b0;
        exp_d  = (op == 2'd1) ? 16'h0000 : ref_mem[ea + b];
        stalls = (stall_sel < 0) ? $urandom_range(0, 2) : int'(stall_sel[b]);
        drain_beat(exp_d, (b == n - 1), 1'b0, stalls);
      end
      if (op == 2'd1) ref_mem[ea] = sdata;
    end
    check("done_resp_valid", resp_valid, 0);
    check("done_req_ready", req_ready, 1);
  endtask

  initial begin
    logic [15:0] keep;
    n_pass         = 0;
    n_total        = 0;
    reset_n        = 1'b0;
    req_valid      = 1'b0;
    req_op         = 2'd0;
    req_base       = 16'h0;
    req_offset     = 16'h0;
    req_len        = 4'd0;
    req_store_data = 16'h0;
    resp_ready     = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    mem[0] = 16'd1;
    mem[1] = 16'd2;
    mem[2] = 16'd3;
    mem[5] = 16'd3;
    for (int i = 0; i < 512; i++) ref_mem[i] = mem[i];

    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_mem_we", mem_write_enable, 0);
    check("rst_mem_re", mem_read_enable, 0);
    check("rst_mem_addr", mem_address, 0);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_ready", req_ready, 1);

    send(2'd0, 16'h0004, 16'h0001, 4'd0, 16'h0000, 0);
    send(2'd1, 16'h0010, 16'hFFFE, 4'd0, 16'hBEEF, 0);
    send(2'd0, 16'h0010, 16'hFFFE, 4'd0, 16'h0000, 0);
    check("store_mem", mem[14], 16'hBEEF);
    send(2'd2, 16'h0000, 16'h0000, 4'd3, 16'h0000, 2);
    send(2'd0, 16'd512, 16'h0000, 4'd0, 16'h0000, 0);
    send(2'd2, 16'd510, 16'h0000, 4'd4, 16'h0000, 0);
    send(2'd0, 16'h0000, 16'hFFFF, 4'd0, 16'h0000, 0);
    send(2'd3, 16'h0000, 16'h0000, 4'd1, 16'h0000, 0);
    send(2'd2, 16'h0000, 16'h0000, 4'd0, 16'h0000, 0);
    send(2'd2, 16'h0000, 16'h0000, 4'd9, 16'h0000, 0);
    send(2'd2, 16'd504, 16'h0000, 4'd8, 16'h0000, 0);
    send(2'd0, 16'd511, 16'h0000, 4'd0, 16'h0000, 1);

    for (int r = 0; r < 60; r++) begin
      send(2'($urandom_range(0, 3)), 16'($urandom_range(0, 530)),
           16'($urandom_range(0, 16)) - 16'd8, 4'($urandom_range(0, 9)),
           16'($urandom), -1);
    end

    // Reset during the ACCESS cycle of a store must suppress the write.
    keep = ref_mem[100];
    @(negedge clk);
    req_valid      = 1'b1;
    req_op         = 2'd1;
    req_base       = 16'd100;
    req_offset     = 16'd0;
    req_store_data = ~keep;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_acc_we", mem_write_enable, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_we", mem_write_enable, 0);
    check("rst_async_ready", req_ready, 0);
    @(negedge clk);
    check("rst_mem_kept", mem[100], keep);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rel_req_ready", req_ready, 1);
    check("rel_resp_valid", resp_valid, 0);
    send(2'd0, 16'd100, 16'h0000, 4'd0, 16'h0000, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
